// File: rtl/segment_word_fifo_pkg.sv
// Shared segment-word definitions used by the FIFO, the step generator and the host interface.
package segment_pkg;

  localparam int SEGMENT_BYTES = 4;
  localparam int SEGMENT_BITS  = 8 * SEGMENT_BYTES;

  typedef logic [SEGMENT_BITS-1:0] segment_t;

endpackage

// File: rtl/segment_word_fifo_packer.sv
// Little-endian byte-to-word packer: the first accepted byte lands in the least significant lane.
module byte_word_packer #(
  parameter int ReadBytes = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  input  logic                   in_ready,
  output logic                   last_byte,
  output logic                   word_valid,
  output logic [8*ReadBytes-1:0] word
);

  localparam int CntBits = (ReadBytes > 1) ? $clog2(ReadBytes) : 1;
  localparam logic [CntBits-1:0] LastCnt = CntBits'(ReadBytes - 1);

  logic [CntBits-1:0]     byte_cnt;
  logic [8*ReadBytes-1:0] shift_reg;
  logic                   accept;

  assign accept     = in_valid && in_ready;
  assign last_byte  = (byte_cnt == LastCnt);
  assign word_valid = accept && last_byte;

  // The final byte bypasses the register so the word can be written the cycle it completes.
  always_comb begin
    word = shift_reg;
    word[8*(ReadBytes-1) +: 8] = in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg[8*byte_cnt +: 8] <= in_byte;
      byte_cnt <= last_byte ? '0 : byte_cnt + CntBits'(1);
    end
  end

endmodule

// File: rtl/segment_word_fifo.sv
// Host byte stream to segment-word show-ahead FIFO feeding the step generator.
module segment_word_fifo
  import segment_pkg::*;
#(
  parameter int ReadBytes = SEGMENT_BYTES,
  parameter int Depth     = 16,
  localparam int AddrBits = $clog2(Depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  output logic                   in_ready,
  output logic                   data_available,
  input  logic                   data_request,
  output logic [8*ReadBytes-1:0] data,
  output logic [AddrBits:0]      level,
  output logic                   underflow
);

  logic [8*ReadBytes-1:0] mem [Depth];
  logic [AddrBits:0]      wr_ptr;
  logic [AddrBits:0]      rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   last_byte;
  logic                   word_valid;
  logic [8*ReadBytes-1:0] word;
  logic                   pop;

  byte_word_packer #(
    .ReadBytes(ReadBytes)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .last_byte (last_byte),
    .word_valid(word_valid),
    .word      (word)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AddrBits] != rd_ptr[AddrBits]) &&
                 (wr_ptr[AddrBits-1:0] == rd_ptr[AddrBits-1:0]);

  // Only the completing byte needs a free slot, so earlier bytes of a word keep flowing while full.
  assign in_ready = !(full && last_byte);
  assign pop      = data_request && !empty;

  assign data_available = !empty;
  assign level          = wr_ptr - rd_ptr;

  always_comb begin
    data = '0;
    if (!empty) data = mem[rd_ptr[AddrBits-1:0]];
  end

  always_ff @(posedge clk) begin
    if (word_valid) mem[wr_ptr[AddrBits-1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      underflow <= 1'b0;
    end else begin
      if (word_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (data_request && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_segment_word_fifo.sv
// Directed and randomized checks of segment_word_fifo against a queue-based reference model.
module tb_segment_word_fifo;
  import segment_pkg::*;

  localparam int ReadBytes = 4;
  localparam int Depth     = 16;
  localparam int AddrBits  = $clog2(Depth);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [7:0]             in_byte = 8'h00;
  logic                   in_ready;
  logic                   data_available;
  logic                   data_request = 1'b0;
  logic [8*ReadBytes-1:0] data;
  logic [AddrBits:0]      level;
  logic                   underflow;

  int nCompared   = 0;
  int nMismatched = 0;

  segment_t   modelQ[$];
  logic [7:0] modelPartial[$];
  logic       modelUf = 1'b0;
  int         wordsPushed = 0;

  segment_word_fifo #(
    .ReadBytes(ReadBytes),
    .Depth    (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .data_available(data_available),
    .data_request  (data_request),
    .data          (data),
    .level         (level),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic modelReady();
    return !(modelQ.size() == Depth && modelPartial.size() == ReadBytes - 1);
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    segment_t expData;
    expData = (modelQ.size() > 0) ? modelQ[0] : '0;
    check1("data_available", 32'(data_available), 32'(modelQ.size() > 0));
    check1("data", data, expData);
    check1("level", 32'(level), 32'(modelQ.size()));
    check1("in_ready", 32'(in_ready), 32'(modelReady()));
    check1("underflow", 32'(underflow), 32'(modelUf));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare just after it.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic req, input logic r);
    logic     ready;
    segment_t w;
    in_valid     = v;
    in_byte      = b;
    data_request = req;
    rst          = r;
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      modelPartial.delete();
      modelUf = 1'b0;
    end else begin
      ready = modelReady();
      if (req && modelQ.size() == 0) modelUf = 1'b1;
      if (req && modelQ.size() > 0) void'(modelQ.pop_front());
      if (v && ready) begin
        modelPartial.push_back(b);
        if (modelPartial.size() == ReadBytes) begin
          w = '0;
          for (int k = 0; k < ReadBytes; k++) w[8*k +: 8] = modelPartial[k];
          modelQ.push_back(w);
          modelPartial.delete();
          wordsPushed++;
        end
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Pack one word and pop it
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    check1("pack_word", data, 32'h12345678);
    check1("pack_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check1("pack_drained", 32'(data_available), 32'd0);

    // Fill, stall on the completing byte, free a slot
    for (int i = 0; i < Depth * ReadBytes; i++)
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < ReadBytes - 1; i++)
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    check1("full_in_ready", 32'(in_ready), 32'd0);
    check1("full_level", 32'(level), 32'(Depth));
    applyStimulus(1'b1, 8'hE7, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE7, 1'b1, 1'b0);
    check1("full_freed", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 8'hE7, 1'b0, 1'b0);
    check1("full_refill", 32'(level), 32'(Depth));
    for (int i = 0; i < 3 * Depth && modelQ.size() > 0; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow is sticky
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check1("underflow_set", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check1("underflow_hold", 32'(underflow), 32'd1);
    check1("underflow_level", 32'(level), 32'd0);

    // Same-cycle push and pop at level 1, then randomized traffic through the wrap
    wordsPushed = 0;
    for (int i = 0; i < 2 * ReadBytes - 1; i++)
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
    check1("pushpop_level", 32'(level), 32'd1);
    for (int i = 0; i < 4000 && wordsPushed < 40; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom),
                    (i % 400 < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0),
                    1'b0);
      check1("level_bound", 32'(level <= Depth), 32'd1);
    end
    check1("wrap_count", 32'(wordsPushed >= 40), 32'd1);
    for (int i = 0; i < 3 * Depth && modelQ.size() > 0; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a word drops the partial bytes
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0);
    check1("midreset_word", data, 32'hDDCCBBAA);
    check1("midreset_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
